// File: rtl/updi_instruction_decoder.sv
// -----------------------------------------------------------------------------
// updi_instruction_decoder
//
// Byte-stream decoder for UPDI instructions. It optionally waits for a SYNC
// byte, decodes the opcode into instruction and field outputs, collects 0..3
// little-endian operand bytes and presents the decoded instruction with a
// valid/ready handshake. Malformed SYNC bytes and illegal opcodes produce a
// one-cycle err pulse and are discarded.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   rx_data/rx_valid   incoming byte stream
//   rx_ready           decoder can accept a byte (low while an instruction is
//                      being presented and while in reset)
//   instruction        decoded instruction class (updi_pkg::updi_instruction)
//   size_a             opcode[3:2] for LDS/STS, opcode[1:0] for all others
//   size_b             opcode[1:0]
//   ptr                opcode[3:2]
//   cs_addr            opcode[3:0]
//   sib                opcode[2]
//   size_c             opcode[1:0]
//   operand            operand bytes, little-endian, zero-extended
//   instr_valid        decoded instruction available
//   instr_ready        consumer takes the instruction
//   err                one-cycle framing/decode error pulse
// -----------------------------------------------------------------------------
package updi_pkg;
  typedef enum logic [2:0] {
    UPDI_LDS    = 3'd0,
    UPDI_LD     = 3'd1,
    UPDI_STS    = 3'd2,
    UPDI_ST     = 3'd3,
    UPDI_LDCS   = 3'd4,
    UPDI_REPEAT = 3'd5,
    UPDI_STCS   = 3'd6,
    UPDI_KEY    = 3'd7
  } updi_instruction;
endpackage

module updi_instruction_decoder
  import updi_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = 8'h55,
  parameter bit         EXPECT_SYNC = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  output updi_instruction instruction,
  output logic [1:0]      size_a,
  output logic [1:0]      size_b,
  output logic [1:0]      ptr,
  output logic [3:0]      cs_addr,
  output logic            sib,
  output logic [1:0]      size_c,
  output logic [23:0]     operand,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic            err
);

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_OPCODE  = 2'd1,
    ST_OPERAND = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_t;

  // With EXPECT_SYNC=0 the SYNC state is never entered.
  localparam state_t IDLE = EXPECT_SYNC ? ST_SYNC : ST_OPCODE;

  state_t          r_state;
  state_t          w_state_nxt;

  updi_instruction r_instruction;
  logic [1:0]      r_size_a;
  logic [1:0]      r_size_b;
  logic [1:0]      r_ptr;
  logic [3:0]      r_cs_addr;
  logic            r_sib;
  logic [1:0]      r_size_c;
  logic [23:0]     r_operand;
  logic [1:0]      r_count;   // index of the next operand byte
  logic [1:0]      r_last;    // index of the final operand byte (N-1)
  logic            r_err;

  logic            w_accept;
  updi_instruction w_instr;
  logic            w_legal;
  logic            w_has_operand;
  logic [1:0]      w_last;
  logic [1:0]      w_size_a;
  logic            w_load_fields;
  logic            w_load_operand;
  logic            w_err_nxt;

  // rx_ready is gated by rst_n so it drops immediately when reset asserts.
  assign rx_ready = rst_n && (r_state != ST_OUTPUT);
  assign w_accept = rx_valid && rx_ready;

  // ---------------------------------------------------------------------------
  // Opcode decode (combinational on the incoming byte)
  // ---------------------------------------------------------------------------
  assign w_instr  = updi_instruction'(rx_data[7:5]);
  assign w_size_a = (w_instr == UPDI_LDS || w_instr == UPDI_STS) ? rx_data[3:2]
                                                                  : rx_data[1:0];

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_legal       = 1'b0;
    w_has_operand = 1'b0;
    w_last        = 2'd0;
    case (w_instr)
      UPDI_LDS, UPDI_STS: begin
        // Operand count is size_a+1; size_a=3 has no defined width.
        w_legal       = !rx_data[4] && (rx_data[3:2] != 2'b11);
        w_has_operand = 1'b1;
        w_last        = rx_data[3:2];
      end
      UPDI_LD, UPDI_ST, UPDI_LDCS: begin
        w_legal = !rx_data[4];
      end
      UPDI_REPEAT: begin
        // Only one- and two-byte repeat counts are defined.
        w_legal       = (rx_data[4:2] == 3'b000) && !rx_data[1];
        w_has_operand = 1'b1;
        w_last        = rx_data[1:0];
      end
      UPDI_STCS: begin
        w_legal       = !rx_data[4];
        w_has_operand = 1'b1;
        w_last        = 2'd0;
      end
      UPDI_KEY: begin
        w_legal = (rx_data[4:3] == 2'b00);
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_err_nxt      = 1'b0;
    w_load_fields  = 1'b0;
    w_load_operand = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (w_accept) begin
          if (rx_data == SYNC_BYTE) begin
            w_state_nxt = ST_OPCODE;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_OPCODE: begin
        if (w_accept) begin
          if (w_legal) begin
            w_load_fields = 1'b1;
            w_state_nxt   = w_has_operand ? ST_OPERAND : ST_OUTPUT;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      ST_OPERAND: begin
        if (w_accept) begin
          w_load_operand = 1'b1;
          if (r_count == r_last) begin
            w_state_nxt = ST_OUTPUT;
          end
        end
      end
      ST_OUTPUT: begin
        if (instr_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Field and operand registers
  // ---------------------------------------------------------------------------
  // NOTE: all datapath registers are reset, since the outputs must read zero
  // during and immediately after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instruction <= UPDI_LDS;
      r_size_a      <= 2'd0;
      r_size_b      <= 2'd0;
      r_ptr         <= 2'd0;
      r_cs_addr     <= 4'd0;
      r_sib         <= 1'b0;
      r_size_c      <= 2'd0;
      r_operand     <= 24'd0;
      r_count       <= 2'd0;
      r_last        <= 2'd0;
    end else if (w_load_fields) begin
      r_instruction <= w_instr;
      r_size_a      <= w_size_a;
      r_size_b      <= rx_data[1:0];
      r_ptr         <= rx_data[3:2];
      r_cs_addr     <= rx_data[3:0];
      r_sib         <= rx_data[2];
      r_size_c      <= rx_data[1:0];
      r_operand     <= 24'd0;
      r_count       <= 2'd0;
      r_last        <= w_last;
    end else if (w_load_operand) begin
      r_operand[{r_count, 3'b000} +: 8] <= rx_data;
      r_count                           <= r_count + 2'd1;
    end
  end

  assign instruction = r_instruction;
  assign size_a      = r_size_a;
  assign size_b      = r_size_b;
  assign ptr         = r_ptr;
  assign cs_addr     = r_cs_addr;
  assign sib         = r_sib;
  assign size_c      = r_size_c;
  assign operand     = r_operand;
  assign instr_valid = (r_state == ST_OUTPUT);
  assign err         = r_err;

endmodule

// File: doc/updi_instruction_decoder.md
UPDI_INSTRUCTION_DECODER -- requirements
Module: updi_instruction_decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameters SHALL be, one per line:
- SYNC_BYTE, 8'h55, value required ahead of each opcode.
- EXPECT_SYNC, 1, when 1 a SYNC byte must precede each opcode; when 0 the first byte is the opcode.
REQ-003 Ports SHALL be, one per line:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  decoder accepts byte
- instruction  out  updi_instruction  decoded instruction (shared enum)
- size_a  out  2  opcode[3:2] (LDS/STS), opcode[1:0] (LD/ST)
- size_b  out  2  opcode[1:0] (LDS/STS/REPEAT)
- ptr  out  2  opcode[3:2] (LD/ST)
- cs_addr  out  4  opcode[3:0] (LDCS/STCS)
- sib  out  1  opcode[2] (KEY)
- size_c  out  2  opcode[1:0] (KEY)
- operand  out  24  assembled operand bytes, little-endian, zero-extended
- instr_valid  out  1  decoded instruction available
- instr_ready  in  1  consumer takes instruction
- err  out  1  one-cycle framing/decode error pulse

Function
REQ-004 States SHALL be: SYNC, OPCODE, OPERAND, OUTPUT.
REQ-005 A byte SHALL be accepted only on a clk edge with rx_valid && rx_ready; rx_ready SHALL be 1 in SYNC, OPCODE and OPERAND, and 0 in OUTPUT and while rst_n is low.
REQ-006 In SYNC, an accepted byte equal to SYNC_BYTE SHALL move to OPCODE; any other byte SHALL be discarded, pulse err and stay in SYNC.
REQ-007 In OPCODE, opcode[7:5] SHALL select instruction: 000 LDS, 001 LD, 010 STS, 011 ST, 100 LDCS, 101 REPEAT, 110 STCS, 111 KEY.
REQ-008 Reserved bits SHALL be checked: opcode[4]=0 for LDS/LD/STS/ST/LDCS/STCS; opcode[4:2]=000 for REPEAT; opcode[4:3]=00 for KEY.
REQ-009 Operand byte count N SHALL be:
- LDS/STS: size_a+1 (size_a=3 is illegal).
- REPEAT: size_b+1 (size_b>=2 is illegal).
- STCS: 1.
- LD/ST/LDCS/KEY: 0.
REQ-010 An illegal opcode (REQ-008/009) SHALL pulse err for one cycle, discard the opcode and return to the idle state (SYNC if EXPECT_SYNC=1, otherwise OPCODE).
REQ-011 A legal opcode SHALL latch all field outputs and clear operand. If N=0 it SHALL go to OUTPUT; otherwise it SHALL go to OPERAND.
REQ-012 In OPERAND, the k-th accepted byte (k=0..N-1) SHALL be written to operand[8k+7:8k]. After byte N-1 the block SHALL go to OUTPUT.
REQ-013 instr_valid SHALL rise on the cycle after the final byte (opcode or operand) is accepted.
REQ-014 While instr_valid=1, all outputs SHALL be held stable until instr_ready=1. The idle state is entered on the next edge and instr_valid falls the same edge.
REQ-015 Fields not used by the decoded instruction SHALL still reflect the raw opcode bits per REQ-003.
REQ-016 rx_valid low mid-frame SHALL stall without timeout and without changing state.
REQ-017 instr_ready asserted while instr_valid=0 SHALL have no effect.

Reset
REQ-018 rst_n low SHALL asynchronously force the idle state, with instr_valid=0, err=0, instruction=UPDI_LDS, all fields=0 and operand=0. This includes mid-frame or during OUTPUT; partial frames are discarded.
REQ-019 After rst_n is released, the first accepted byte SHALL be treated as a SYNC byte (or as the opcode if EXPECT_SYNC=0).

Verification
REQ-020 Bytes 55,08 -> UPDI_LDS, size_a=2, size_b=0, N=3. Then bytes 00,10,80 -> operand=24'h801000, instr_valid one cycle after 80.
REQ-021 Bytes 55,C2,59 -> UPDI_STCS, cs_addr=2, operand=24'h000059. Hold instr_ready=0 for 5 cycles -> outputs stable, rx_ready=0.
REQ-022 Bytes 55,A1,34,12 -> UPDI_REPEAT, operand=24'h001234. Bytes 55,A2 -> err pulse, return to SYNC, no instr_valid.
REQ-023 Byte 3C in SYNC -> err pulse, stays in SYNC. Then 55,E5 -> UPDI_KEY, sib=1, size_c=1, N=0.
REQ-024 rst_n low after 55,04,00 (LDS, one of two operand bytes received) -> all outputs 0. Then 55,80 -> UPDI_LDCS, cs_addr=0, correct decode.
